// File: rtl/conv_kernel_regfile.sv
// ---------------------------------------------------------------------------
// conv_kernel_regfile
//
// Kernel/window register file for the convolution core. Sits between the
// coefficient loader and the MAC array.
//   * NWR independent write lanes, each with its own address.
//   * NRD registered read ports, so every tap is fetched in one cycle.
//   * A streaming load FSM that fills entries 0..DEPTH-1 in order from a
//     valid/ready source.
//
// Optional build feature: define REGFILE_PARITY_EN to store an even-parity
// bit with every entry. This adds the ports inj_perr (test-only parity
// corruption) and rd_perr (per-port parity error, registered with rd_data).
//
// Ports
//   clk       in   rising-edge clock
//   rst       in   asynchronous active-high reset (clears the whole file)
//   wr_en     in   [NWR]        per-lane write enable
//   wr_addr   in   [NWR*ADDR]   lane i address at [i*ADDR +: ADDR]
//   wr_data   in   [NWR*WIDTH]  lane i data at [i*WIDTH +: WIDTH]
//   rd_en     in   read strobe shared by all ports
//   rd_addr   in   [NRD*ADDR]   port j address at [j*ADDR +: ADDR]
//   rd_data   out  [NRD*WIDTH]  port j data at [j*WIDTH +: WIDTH], registered
//   rd_valid  out  high for the one cycle after an accepted read
//   ld_start  in   start (or restart) a stream load at address 0
//   ld_valid  in   stream word valid
//   ld_data   in   [WIDTH] stream word
//   ld_ready  out  stream word can be accepted this cycle
//   ld_done   out  one-cycle pulse after the last entry has been streamed
//   loaded    out  a complete stream load has finished since reset
//   inj_perr  in   (REGFILE_PARITY_EN only) invert stored parity on writes
//   rd_perr   out  (REGFILE_PARITY_EN only) [NRD] parity mismatch per port
//
// ADDR must be wide enough to address every entry (2**ADDR >= DEPTH).
// ---------------------------------------------------------------------------
module conv_kernel_regfile #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 9,
    parameter int ADDR  = 4,
    parameter int NWR   = 5,
    parameter int NRD   = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NWR-1:0]         wr_en,
    input  logic [NWR*ADDR-1:0]    wr_addr,
    input  logic [NWR*WIDTH-1:0]   wr_data,
    input  logic                   rd_en,
    input  logic [NRD*ADDR-1:0]    rd_addr,
    output logic [NRD*WIDTH-1:0]   rd_data,
    output logic                   rd_valid,
    input  logic                   ld_start,
    input  logic                   ld_valid,
    input  logic [WIDTH-1:0]       ld_data,
    output logic                   ld_ready,
    output logic                   ld_done,
    output logic                   loaded
`ifdef REGFILE_PARITY_EN
    ,
    input  logic                   inj_perr,
    output logic [NRD-1:0]         rd_perr
`endif
);

    // One extra bit so DEPTH itself is representable for range checks.
    localparam logic [ADDR:0]   DEPTH_A = (ADDR+1)'(DEPTH);
    localparam logic [ADDR-1:0] LAST_A  = ADDR'(DEPTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // -----------------------------------------------------------------------
    // Storage
    // -----------------------------------------------------------------------
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
`ifdef REGFILE_PARITY_EN
    logic             par_q [DEPTH];
    logic             par_d [DEPTH];
`endif

    // -----------------------------------------------------------------------
    // Control state
    // -----------------------------------------------------------------------
    state_t          state_q, state_d;
    logic [ADDR-1:0] ld_ptr_q, ld_ptr_d;
    logic            loaded_q, loaded_d;
    logic            ld_xfer;
    logic            any_wr;
    logic            rd_accept;

    // Unpacked views of the write lanes.
    logic [ADDR-1:0]  lane_addr [NWR];
    logic [WIDTH-1:0] lane_data [NWR];

    genvar gi;
    generate
        for (gi = 0; gi < NWR; gi++) begin : g_lane
            assign lane_addr[gi] = wr_addr[gi*ADDR +: ADDR];
            assign lane_data[gi] = wr_data[gi*WIDTH +: WIDTH];
        end
    endgenerate

    assign any_wr    = |wr_en;
    // A read in the same cycle as any direct write is dropped; the write wins.
    assign rd_accept = rd_en & ~any_wr;

    // -----------------------------------------------------------------------
    // Load FSM: next state and outputs
    // -----------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        ld_ptr_d = ld_ptr_q;
        loaded_d = loaded_q;
        ld_ready = 1'b0;
        ld_done  = 1'b0;
        ld_xfer  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (ld_start) begin
                    state_d  = S_LOAD;
                    ld_ptr_d = '0;
                end
            end

            S_LOAD: begin
                // Direct writes own the file this cycle; back-pressure the
                // stream instead of dropping its word.
                ld_ready = ~any_wr;
                ld_xfer  = ld_valid & ld_ready;
                if (ld_xfer) begin
                    if (ld_ptr_q == LAST_A) begin
                        state_d  = S_DONE;
                        ld_ptr_d = '0;
                    end else begin
                        ld_ptr_d = ld_ptr_q + ADDR'(1);
                    end
                end
                // A restart overrides any pointer advance in the same cycle.
                // A word transferred alongside it has still been written.
                if (ld_start) begin
                    state_d  = S_LOAD;
                    ld_ptr_d = '0;
                end
            end

            S_DONE: begin
                ld_done  = 1'b1;
                loaded_d = 1'b1;
                state_d  = S_IDLE;
            end

            default: begin
                state_d  = S_IDLE;
                ld_ptr_d = '0;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Next memory contents. The stream word is applied first, then the lanes
    // in ascending order so the highest-index lane on a shared address wins.
    // Only addresses below DEPTH ever match an entry, so out-of-range lanes
    // fall through without effect.
    // -----------------------------------------------------------------------
    always_comb begin
        for (int e = 0; e < DEPTH; e++) begin
            mem_d[e] = mem_q[e];
`ifdef REGFILE_PARITY_EN
            par_d[e] = par_q[e];
`endif
            if (ld_xfer && (ld_ptr_q == ADDR'(e))) begin
                mem_d[e] = ld_data;
`ifdef REGFILE_PARITY_EN
                par_d[e] = (^ld_data) ^ inj_perr;
`endif
            end
            for (int i = 0; i < NWR; i++) begin
                if (wr_en[i] && (lane_addr[i] == ADDR'(e))) begin
                    mem_d[e] = lane_data[i];
`ifdef REGFILE_PARITY_EN
                    par_d[e] = (^lane_data[i]) ^ inj_perr;
`endif
                end
            end
        end
    end

    // -----------------------------------------------------------------------
    // State and storage registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            ld_ptr_q <= '0;
            loaded_q <= 1'b0;
            for (int e = 0; e < DEPTH; e++) begin
                mem_q[e] <= '0;
`ifdef REGFILE_PARITY_EN
                par_q[e] <= 1'b0;
`endif
            end
        end else begin
            state_q  <= state_d;
            ld_ptr_q <= ld_ptr_d;
            loaded_q <= loaded_d;
            for (int e = 0; e < DEPTH; e++) begin
                mem_q[e] <= mem_d[e];
`ifdef REGFILE_PARITY_EN
                par_q[e] <= par_d[e];
`endif
            end
        end
    end

    assign loaded = loaded_q;

    // -----------------------------------------------------------------------
    // Read ports: registered, holding their value when no read is accepted.
    // -----------------------------------------------------------------------
    logic rd_valid_q, rd_valid_d;

    assign rd_valid_d = rd_accept;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= rd_valid_d;
        end
    end

    assign rd_valid = rd_valid_q;

    generate
        for (gi = 0; gi < NRD; gi++) begin : g_rd
            logic [ADDR-1:0]  port_addr;
            logic             port_in_range;
            logic [WIDTH-1:0] port_data_q, port_data_d;

            assign port_addr     = rd_addr[gi*ADDR +: ADDR];
            assign port_in_range = ({1'b0, port_addr} < DEPTH_A);

            always_comb begin
                port_data_d = port_data_q;
                if (rd_accept) begin
                    port_data_d = port_in_range ? mem_q[port_addr] : '0;
                end
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    port_data_q <= '0;
                end else begin
                    port_data_q <= port_data_d;
                end
            end

            assign rd_data[gi*WIDTH +: WIDTH] = port_data_q;

`ifdef REGFILE_PARITY_EN
            logic port_perr_q, port_perr_d;

            // Recompute parity of the stored word and compare with the
            // stored bit; an out-of-range port never flags an error.
            always_comb begin
                port_perr_d = port_perr_q;
                if (rd_accept) begin
                    port_perr_d = port_in_range ?
                        ((^mem_q[port_addr]) ^ par_q[port_addr]) : 1'b0;
                end
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    port_perr_q <= 1'b0;
                end else begin
                    port_perr_q <= port_perr_d;
                end
            end

            assign rd_perr[gi] = port_perr_q;
`endif
        end
    endgenerate

endmodule

// File: tb/tb_conv_kernel_regfile.sv
// ---------------------------------------------------------------------------
// tb_conv_kernel_regfile
//
// Directed bench for conv_kernel_regfile with the default parameters
// (WIDTH=8, DEPTH=9, ADDR=4, NWR=5, NRD=3). A vector table covers direct
// writes and reads; hand-written sequences cover the stream load, lane
// collisions with the stream, asynchronous reset mid-load and, when
// REGFILE_PARITY_EN is defined, parity error injection.
// ---------------------------------------------------------------------------
module tb_conv_kernel_regfile;

    logic        clk;
    logic        rst;
    logic [4:0]  wr_en;
    logic [19:0] wr_addr;
    logic [39:0] wr_data;
    logic        rd_en;
    logic [11:0] rd_addr;
    logic [23:0] rd_data;
    logic        rd_valid;
    logic        ld_start;
    logic        ld_valid;
    logic [7:0]  ld_data;
    logic        ld_ready;
    logic        ld_done;
    logic        loaded;
`ifdef REGFILE_PARITY_EN
    logic        inj_perr;
    logic [2:0]  rd_perr;
`endif

    conv_kernel_regfile #(
        .WIDTH (8),
        .DEPTH (9),
        .ADDR  (4),
        .NWR   (5),
        .NRD   (3)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .rd_en    (rd_en),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .ld_start (ld_start),
        .ld_valid (ld_valid),
        .ld_data  (ld_data),
        .ld_ready (ld_ready),
        .ld_done  (ld_done),
        .loaded   (loaded)
`ifdef REGFILE_PARITY_EN
        ,
        .inj_perr (inj_perr),
        .rd_perr  (rd_perr)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One accepted read, then confirm rd_valid drops and rd_data holds.
    task automatic do_read(input string name, input logic [11:0] addr, input logic [23:0] exp);
        rd_en   = 1'b1;
        rd_addr = addr;
        tick();
        rd_en = 1'b0;
        $display("read  %s: addr=%h rd_data=%h rd_valid=%b", name, addr, rd_data, rd_valid);
        check({name, "_data"}, 32'(rd_data), 32'(exp));
        check({name, "_valid"}, 32'(rd_valid), 32'd1);
        tick();
        check({name, "_hold"}, 32'(rd_data), 32'(exp));
        check({name, "_valid_drop"}, 32'(rd_valid), 32'd0);
    endtask

    // Stream words base+1 .. base+9 into entries 0..8. If inj_at >= 0, a
    // lane-0 write of 8'hF0 to inj_addr is issued in the cycle word inj_at is
    // first offered; that cycle must not accept the stream word.
    task automatic stream_load(input string name, input logic [7:0] base,
                               input int inj_at, input logic [3:0] inj_addr);
        int  k;
        int  cyc;
        bit  injected;
        logic acc;
        k        = 0;
        cyc      = 0;
        injected = 1'b0;
        ld_start = 1'b1;
        tick();
        ld_start = 1'b0;
        while (k < 9 && cyc < 40) begin
            ld_valid = 1'b1;
            ld_data  = base + 8'(k + 1);
            if (k == inj_at && !injected) begin
                injected = 1'b1;
                wr_en    = 5'b00001;
                wr_addr  = {16'h0, inj_addr};
                wr_data  = {32'h0, 8'hF0};
                #1;
                check({name, "_ready_during_wr"}, 32'(ld_ready), 32'd0);
            end else begin
                #1;
                check({name, "_ready"}, 32'(ld_ready), 32'd1);
            end
            acc = ld_ready;
            @(posedge clk);
            #1;
            wr_en = 5'b0;
            $display("load  %s: word=%h accepted=%b", name, ld_data, acc);
            if (acc) k++;
            cyc++;
        end
        ld_valid = 1'b0;
        check({name, "_words_accepted"}, 32'(k), 32'd9);
        check({name, "_done_pulse"}, 32'(ld_done), 32'd1);
        tick();
        check({name, "_done_drop"}, 32'(ld_done), 32'd0);
        check({name, "_loaded"}, 32'(loaded), 32'd1);
        check({name, "_ready_idle"}, 32'(ld_ready), 32'd0);
    endtask

    typedef struct {
        logic [4:0]  wr_en;
        logic [19:0] wr_addr;
        logic [39:0] wr_data;
        logic        rd_en;
        logic [11:0] rd_addr;
        logic [23:0] exp_data;
        logic        exp_valid;
    } vec_t;

    localparam int NV = 14;
    vec_t vecs [NV];

    initial begin
        // Addresses/data are packed {lane4..lane0} and {port2..port0}.
        vecs[0]  = '{5'b00000, 20'h00000, 40'h0000000000, 1'b1, 12'h210, 24'h000000, 1'b1};
        vecs[1]  = '{5'b00011, 20'h00033, 40'h00000055AA, 1'b0, 12'h000, 24'h000000, 1'b0};
        vecs[2]  = '{5'b00000, 20'h00000, 40'h0000000000, 1'b1, 12'h333, 24'h555555, 1'b1};
        vecs[3]  = '{5'b00000, 20'h00000, 40'h0000000000, 1'b0, 12'h000, 24'h555555, 1'b0};
        vecs[4]  = '{5'b11100, 20'h0C800, 40'h1199880000, 1'b1, 12'h333, 24'h555555, 1'b0};
        vecs[5]  = '{5'b00000, 20'h00000, 40'h0000000000, 1'b1, 12'hC80, 24'h008811, 1'b1};
        vecs[6]  = '{5'b10101, 20'h50505, 40'h0400020001, 1'b0, 12'h000, 24'h008811, 1'b0};
        vecs[7]  = '{5'b00011, 20'h0009F, 40'h000000EEFF, 1'b0, 12'h000, 24'h008811, 1'b0};
        vecs[8]  = '{5'b00000, 20'h00000, 40'h0000000000, 1'b1, 12'h9FC, 24'h000000, 1'b1};
        vecs[9]  = '{5'b00000, 20'h00000, 40'h0000000000, 1'b1, 12'h210, 24'h000011, 1'b1};
        vecs[10] = '{5'b00000, 20'h00000, 40'h0000000000, 1'b1, 12'h543, 24'h040055, 1'b1};
        vecs[11] = '{5'b00000, 20'h00000, 40'h0000000000, 1'b1, 12'h876, 24'h880000, 1'b1};
        vecs[12] = '{5'b01000, 20'h06000, 40'h0066000000, 1'b1, 12'h876, 24'h880000, 1'b0};
        vecs[13] = '{5'b00000, 20'h00000, 40'h0000000000, 1'b1, 12'h876, 24'h880066, 1'b1};

        rst      = 1'b1;
        wr_en    = '0;
        wr_addr  = '0;
        wr_data  = '0;
        rd_en    = 1'b0;
        rd_addr  = '0;
        ld_start = 1'b0;
        ld_valid = 1'b0;
        ld_data  = '0;
`ifdef REGFILE_PARITY_EN
        inj_perr = 1'b0;
`endif
        tick();
        tick();
        rst = 1'b0;

        // Reset state.
        check("reset_rd_data",  32'(rd_data),  32'd0);
        check("reset_rd_valid", 32'(rd_valid), 32'd0);
        check("reset_ld_ready", 32'(ld_ready), 32'd0);
        check("reset_ld_done",  32'(ld_done),  32'd0);
        check("reset_loaded",   32'(loaded),   32'd0);

        // Direct write/read vector table.
        for (int i = 0; i < NV; i++) begin
            wr_en   = vecs[i].wr_en;
            wr_addr = vecs[i].wr_addr;
            wr_data = vecs[i].wr_data;
            rd_en   = vecs[i].rd_en;
            rd_addr = vecs[i].rd_addr;
            tick();
            $display("vec %0d: wr_en=%b rd_en=%b rd_addr=%h -> rd_data=%h rd_valid=%b",
                     i, vecs[i].wr_en, vecs[i].rd_en, vecs[i].rd_addr, rd_data, rd_valid);
            check($sformatf("vec%0d_rd_data", i),  32'(rd_data),  32'(vecs[i].exp_data));
            check($sformatf("vec%0d_rd_valid", i), 32'(rd_valid), 32'(vecs[i].exp_valid));
        end
        wr_en = '0;
        rd_en = 1'b0;
        tick();
        check("idle_ld_ready", 32'(ld_ready), 32'd0);
        check("preload_loaded", 32'(loaded), 32'd0);

        // Plain stream load 1..9.
        stream_load("load1", 8'h00, -1, 4'd0);
        do_read("load1_rd", 12'h840, 24'h090501);

        // Direct write to addr 7 before the stream gets there: stream wins.
        stream_load("load2", 8'h20, 3, 4'd7);
        do_read("load2_rd", 12'h873, 24'h292824);

        // Direct write to addr 7 after the stream passed it: write stays.
        stream_load("load3", 8'h30, 8, 4'd7);
        do_read("load3_rd", 12'h876, 24'h39F037);

        // Asynchronous reset in the middle of a stream load.
        ld_start = 1'b1;
        tick();
        ld_start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            ld_valid = 1'b1;
            ld_data  = 8'h41 + 8'(k);
            tick();
        end
        #3;
        rst = 1'b1;
        #1;
        check("midrst_rd_data",  32'(rd_data),  32'd0);
        check("midrst_rd_valid", 32'(rd_valid), 32'd0);
        check("midrst_ld_ready", 32'(ld_ready), 32'd0);
        check("midrst_ld_done",  32'(ld_done),  32'd0);
        check("midrst_loaded",   32'(loaded),   32'd0);
        tick();
        rst = 1'b0;
        #1;
        check("postrst_ld_ready", 32'(ld_ready), 32'd0);
        ld_valid = 1'b0;
        tick();
        do_read("postrst_rd", 12'h830, 24'h000000);
        check("postrst_loaded", 32'(loaded), 32'd0);

`ifdef REGFILE_PARITY_EN
        // Corrupt parity on addr 2, write addr 1 cleanly, read both.
        wr_en    = 5'b00001;
        wr_addr  = 20'h00002;
        wr_data  = 40'h000000005A;
        inj_perr = 1'b1;
        tick();
        inj_perr = 1'b0;
        wr_addr  = 20'h00001;
        wr_data  = 40'h0000000007;
        tick();
        wr_en = '0;
        rd_en   = 1'b1;
        rd_addr = 12'h210;
        tick();
        rd_en = 1'b0;
        $display("read  parity: rd_data=%h rd_perr=%b", rd_data, rd_perr);
        check("parity_rd_data", 32'(rd_data), 32'h5A0700);
        check("parity_rd_perr", 32'(rd_perr), 32'b100);
        rd_en   = 1'b1;
        rd_addr = 12'h011;
        tick();
        rd_en = 1'b0;
        check("parity_clean_perr", 32'(rd_perr), 32'b000);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/conv_kernel_regfile.md
Name: conv_kernel_regfile

Overview:
Parametrised kernel/window register file for the convolution core. It supersedes the fixed 5-port, 8-bit file:
- NWR independent write lanes, each with its own address.
- NRD parallel registered read ports, so all taps are fetched in one cycle.
- A streaming load FSM that fills the file sequentially from a valid/ready source.

It sits between the coefficient loader and the MAC array.

Parameters:
WIDTH, 8, data bits per entry
DEPTH, 9, number of entries (e.g. 3x3 kernel)
ADDR, 4, address bits; must satisfy 2**ADDR >= DEPTH
NWR, 5, parallel write lanes
NRD, 3, parallel read ports

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
wr_en  in  NWR  per-lane write enable
wr_addr  in  NWR*ADDR  lane i address at [i*ADDR +: ADDR]
wr_data  in  NWR*WIDTH  lane i data at [i*WIDTH +: WIDTH]
rd_en  in  1  read strobe for all ports
rd_addr  in  NRD*ADDR  port j address at [j*ADDR +: ADDR]
rd_data  out  NRD*WIDTH  port j data at [j*WIDTH +: WIDTH], registered
rd_valid  out  1  high one cycle after an accepted read
ld_start  in  1  start a sequential stream load at address 0
ld_valid  in  1  stream word valid
ld_data  in  WIDTH  stream word
ld_ready  out  1  FSM can accept a stream word
ld_done  out  1  one-cycle pulse after entry DEPTH-1 is written
loaded  out  1  all DEPTH entries written since reset

Behaviour:
- Reset (rst=1, async): all entries = 0; rd_data = 0; rd_valid = 0; ld_ready = 0; ld_done = 0; loaded = 0; FSM = IDLE; load pointer = 0.
- Direct write: each lane with wr_en[i]=1 and wr_addr < DEPTH writes on the rising edge.
  - Lanes with address >= DEPTH are dropped silently.
  - Two lanes on the same address in one cycle: the highest-index lane wins.
- Read: rd_en=1 and wr_en==0 -> rd_data registered next cycle (latency 1); rd_valid=1 for that cycle only.
  - A port with address >= DEPTH returns 0.
  - rd_data holds its value when there is no read.
- rd_en and any wr_en in the same cycle: the write is performed; the read is ignored and rd_valid=0 next cycle. No read-during-write bypass.
- Load FSM states:
  - IDLE: ld_ready=0. ld_start -> LOAD, pointer=0.
  - LOAD: ld_ready = ~(|wr_en). A transfer is ld_valid & ld_ready; it writes ld_data to Mem[pointer] and increments pointer.
    - Transfer at pointer==DEPTH-1 -> DONE, pointer wraps to 0.
    - ld_start while in LOAD restarts at pointer 0; any data already written is kept.
  - DONE: ld_done=1 for one cycle; loaded set; -> IDLE.
- Direct writes take priority over the stream: ld_ready drops in any cycle where a wr_en bit is set, so no stream word is lost.
- rd_en is accepted in every FSM state.
- loaded is cleared only by rst.
- rst asserted mid-load: aborts immediately to IDLE; the file is cleared.

Optional Feature:
Macro: REGFILE_PARITY_EN.
- Defined:
  - Each entry stores an extra even-parity bit, computed on every write.
  - Extra output rd_perr [NRD] is registered alongside rd_data; bit j=1 when the stored parity of port j's entry mismatches.
  - Extra input inj_perr (test only) flips the stored parity bit on writes while high.
  - rd_perr resets to 0.
- Undefined: no parity storage; ports rd_perr and inj_perr do not exist.

Test Plan:
- Reset, then rd_en with rd_addr={2,1,0} -> next cycle rd_data all 0, rd_valid=1; ld_ready=0; loaded=0.
- wr_en=5'b00011, lane0 addr3 data 8'hAA, lane1 addr3 data 8'h55; then read addr3 -> 8'h55, because lane 1 wins.
- ld_start, then stream 1..9 with ld_valid held high -> ld_done pulses one cycle after word 9; loaded=1; reading addr {0,4,8} -> {1,5,9}.
- During LOAD, pulse wr_en on lane0 (addr 7, data 8'hF0) mid-stream -> ld_ready=0 that cycle and no stream word is dropped.
  - If the stream has not yet reached addr 7, the stream later overwrites it with its value.
  - If it has, the entry reads 8'hF0.
- rd_en with wr_en in the same cycle -> write lands and rd_valid stays 0; addr 12 read -> 0; addr 12 write -> no entry changes.
- Assert rst mid-load after 4 words -> all outputs at reset values; reading addr 0 returns 0.
  - With REGFILE_PARITY_EN: write addr 2 with inj_perr=1, then read -> rd_perr[j]=1 for the port reading addr 2.
